// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave cook timer.
// Holds the sequencing states and BCD time constants.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    COOK,
    PAUSE,
    DONE
  } state_t;

  localparam logic [15:0] ZERO_TIME = 16'h0000;
  localparam logic [7:0]  SEC_WRAP  = 8'h59;
  localparam logic [15:0] ONE_SEC   = 16'h0001;

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// Keypad, tick, door and display/power signals of the cook timer.
// master drives the requests, slave is the controller.
interface cook_timer_ctrl_if;

  logic        sec_tick;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        cancel;
  logic        door_closed;
  logic [15:0] time_bcd;
  logic        mag_on;
  logic        done;
  logic        busy;

  modport master (
    output sec_tick, key_valid, key_digit,
    output start, cancel, door_closed,
    input  time_bcd, mag_on, done, busy
  );

  modport slave (
    input  sec_tick, key_valid, key_digit,
    input  start, cancel, door_closed,
    output time_bcd, mag_on, done, busy
  );

endinterface

// File: rtl/bcd_mmss_down.sv
// MM:SS BCD time register with clear, digit shift-in and
// one-second borrow-chain decrement that never goes below 0000.
module bcd_mmss_down
  import timer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        zero,
  input  logic        load,
  input  logic [3:0]  digit,
  input  logic        dec,
  output logic [15:0] time_bcd,
  output logic        is_zero
);

  logic [15:0] t_q;
  logic [15:0] t_dec;

  assign time_bcd = t_q;
  assign is_zero  = (t_q == ZERO_TIME);

  // borrow chain: sec_ones, then seconds wrap to 59, then minutes
  always_comb begin
    t_dec = t_q;
    if (t_q[3:0] != 4'd0) begin
      t_dec[3:0] = t_q[3:0] - 4'd1;
    end else if (t_q[7:4] != 4'd0) begin
      t_dec[3:0] = 4'd9;
      t_dec[7:4] = t_q[7:4] - 4'd1;
    end else begin
      t_dec[7:0] = SEC_WRAP;
      if (t_q[11:8] != 4'd0) begin
        t_dec[11:8] = t_q[11:8] - 4'd1;
      end else begin
        t_dec[11:8]  = 4'd9;
        t_dec[15:12] = t_q[15:12] - 4'd1;
      end
    end
  end

  // time register: clear beats shift-load beats decrement
  always_ff @(posedge clock) begin
    if (!clear) begin
      t_q <= ZERO_TIME;
    end else if (zero) begin
      t_q <= ZERO_TIME;
    end else if (load) begin
      t_q <= {t_q[11:0], digit};
    end else if (dec && !is_zero) begin
      t_q <= t_dec;
    end
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer sequencer: digit entry, cook/pause/cancel
// with door interlock, per-second countdown and end-of-cook beep.
module cook_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic               clock,
  input  logic               clear,
  cook_timer_ctrl_if.slave   bus
);

  localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS);

  state_t      state_q, state_n;
  logic [2:0]  dig_q, dig_n;
  logic [3:0]  beep_q, beep_n;
  logic        zero, load, dec;
  logic        is_zero;
  logic        key_ok;
  logic [15:0] time_bcd;

  assign key_ok = bus.key_valid && (bus.key_digit <= 4'd9);

  bcd_mmss_down u_time (
    .clock    (clock),
    .clear    (clear),
    .zero     (zero),
    .load     (load),
    .digit    (bus.key_digit),
    .dec      (dec),
    .time_bcd (time_bcd),
    .is_zero  (is_zero)
  );

  // next state; cancel > door open > start > key > tick
  always_comb begin
    state_n = state_q;
    dig_n   = dig_q;
    beep_n  = beep_q;
    zero    = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_ok) begin
          load    = 1'b1;
          dig_n   = 3'd1;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (bus.cancel) begin
          zero    = 1'b1;
          dig_n   = 3'd0;
          state_n = IDLE;
        end else if (bus.start && bus.door_closed && !is_zero) begin
          state_n = COOK;
        end else if (key_ok && dig_q < 3'd4) begin
          load  = 1'b1;
          dig_n = dig_q + 3'd1;
        end
      end
      COOK: begin
        if (bus.cancel || !bus.door_closed) begin
          state_n = PAUSE;
        end else if (bus.sec_tick) begin
          dec = 1'b1;
          if (time_bcd == ONE_SEC) begin
            beep_n  = 4'd0;
            state_n = DONE;
          end
        end
      end
      PAUSE: begin
        if (bus.cancel) begin
          zero    = 1'b1;
          dig_n   = 3'd0;
          state_n = IDLE;
        end else if (bus.start && bus.door_closed) begin
          state_n = COOK;
        end
      end
      DONE: begin
        if (bus.cancel || bus.key_valid || !bus.door_closed) begin
          beep_n  = 4'd0;
          dig_n   = 3'd0;
          state_n = IDLE;
        end else if (bus.sec_tick) begin
          if (beep_q + 4'd1 == BEEP_LAST) begin
            beep_n  = 4'd0;
            dig_n   = 3'd0;
            state_n = IDLE;
          end else begin
            beep_n = beep_q + 4'd1;
          end
        end
      end
      default: begin
        zero    = 1'b1;
        dig_n   = 3'd0;
        beep_n  = 4'd0;
        state_n = IDLE;
      end
    endcase
  end

  // state, digit count and beep count registers
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= IDLE;
      dig_q   <= 3'd0;
      beep_q  <= 4'd0;
    end else begin
      state_q <= state_n;
      dig_q   <= dig_n;
      beep_q  <= beep_n;
    end
  end

  assign bus.time_bcd = time_bcd;
  assign bus.mag_on   = (state_q == COOK) && bus.door_closed;
  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q == COOK) || (state_q == PAUSE);

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_cook_timer_ctrl;

  localparam int BT = 3;

  logic clock = 1'b0;
  logic clear = 1'b0;

  cook_timer_ctrl_if bus();

  cook_timer_ctrl #(.BEEP_TICKS(BT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef enum int {M_IDLE, M_ENTRY, M_COOK, M_PAUSE, M_DONE} mst_t;

  mst_t        m_st   = M_IDLE;
  int          m_dig  = 0;
  int          m_beep = 0;
  logic [15:0] m_time = 16'h0000;
  bit          cmp_en = 1'b0;

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] enc(int m, int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // one second less, in minutes/seconds arithmetic
  function automatic logic [15:0] sec_less(logic [15:0] t);
    int m, s;
    m = int'(t[15:12]) * 10 + int'(t[11:8]);
    s = int'(t[7:4]) * 10 + int'(t[3:0]);
    if (m == 0 && s == 0) return t;
    if (s > 0) s = s - 1;
    else begin
      s = 59;
      m = m - 1;
    end
    return enc(m, s);
  endfunction

  task automatic go_idle();
    m_st   = M_IDLE;
    m_time = 16'h0000;
    m_dig  = 0;
    m_beep = 0;
  endtask

  task automatic model_step();
    bit kok;
    kok = bus.key_valid && (bus.key_digit <= 4'd9);
    if (!clear) begin
      go_idle();
      return;
    end
    case (m_st)
      M_IDLE:
        if (kok) begin
          m_time = {12'h000, bus.key_digit};
          m_dig  = 1;
          m_st   = M_ENTRY;
        end
      M_ENTRY:
        if (bus.cancel) go_idle();
        else if (bus.start && bus.door_closed && m_time != 16'h0000)
          m_st = M_COOK;
        else if (kok && m_dig < 4) begin
          m_time = {m_time[11:0], bus.key_digit};
          m_dig  = m_dig + 1;
        end
      M_COOK:
        if (bus.cancel || !bus.door_closed) m_st = M_PAUSE;
        else if (bus.sec_tick) begin
          m_time = sec_less(m_time);
          if (m_time == 16'h0000) begin
            m_st   = M_DONE;
            m_beep = 0;
          end
        end
      M_PAUSE:
        if (bus.cancel) go_idle();
        else if (bus.start && bus.door_closed) m_st = M_COOK;
      M_DONE:
        if (bus.cancel || bus.key_valid || !bus.door_closed) go_idle();
        else if (bus.sec_tick) begin
          m_beep = m_beep + 1;
          if (m_beep == BT) go_idle();
        end
      default: go_idle();
    endcase
  endtask

  task automatic chk(string n, logic [15:0] got, logic [15:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s at %0t: got %h want %h", n, $time, got, exp);
    end
  endtask

  // compare every cycle against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_time", bus.time_bcd, m_time);
      chk("m_mag", 16'(bus.mag_on),
          16'(m_st == M_COOK && bus.door_closed));
      chk("m_done", 16'(bus.done), 16'(m_st == M_DONE));
      chk("m_busy", 16'(bus.busy),
          16'(m_st == M_COOK || m_st == M_PAUSE));
    end
  end

  task automatic step(bit kv = 0, logic [3:0] kd = 4'd0,
                      bit st = 0, bit cn = 0, bit tk = 0);
    bus.key_valid = kv;
    bus.key_digit = kd;
    bus.start     = st;
    bus.cancel    = cn;
    bus.sec_tick  = tk;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic key(logic [3:0] d);
    step(1'b1, d);
  endtask

  task automatic start_req();
    step(1'b0, 4'd0, 1'b1);
  endtask

  task automatic cancel_req();
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'd0;
    bus.start       = 1'b0;
    bus.cancel      = 1'b0;
    bus.sec_tick    = 1'b0;
    bus.door_closed = 1'b1;
    clear = 1'b0;
    step();
    step();
    cmp_en = 1'b1;
    chk("rst_time", bus.time_bcd, 16'h0000);
    chk("rst_mag", 16'(bus.mag_on), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    clear = 1'b1;
    step();

    key(4'd1); key(4'd3); key(4'd0);
    start_req();
    chk("cook_0130", bus.time_bcd, 16'h0130);
    chk("cook_mag", 16'(bus.mag_on), 16'd1);
    ticks(1);
    chk("tick_0129", bus.time_bcd, 16'h0129);
    ticks(30);
    chk("wrap_0059", bus.time_bcd, 16'h0059);
    cancel_req(); cancel_req();

    key(4'd0); key(4'd0); key(4'd0); key(4'd2);
    start_req();
    ticks(1);
    chk("at_0001", bus.time_bcd, 16'h0001);
    ticks(1);
    chk("end_time", bus.time_bcd, 16'h0000);
    chk("end_done", 16'(bus.done), 16'd1);
    chk("end_mag", 16'(bus.mag_on), 16'd0);
    ticks(2);
    chk("beep_hold", 16'(bus.done), 16'd1);
    ticks(1);
    chk("beep_off", 16'(bus.done), 16'd0);
    chk("beep_idle", 16'(bus.busy), 16'd0);

    key(4'd4); key(4'd5);
    start_req();
    bus.door_closed = 1'b0;
    #1;
    chk("door_mag", 16'(bus.mag_on), 16'd0);
    step();
    chk("door_pause", 16'(bus.busy), 16'd1);
    ticks(3);
    chk("pause_hold", bus.time_bcd, 16'h0045);
    bus.door_closed = 1'b1;
    start_req();
    chk("resume_time", bus.time_bcd, 16'h0045);
    chk("resume_mag", 16'(bus.mag_on), 16'd1);
    cancel_req(); cancel_req();

    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("five_keys", bus.time_bcd, 16'h1234);
    key(4'd12);
    chk("bad_key", bus.time_bcd, 16'h1234);
    cancel_req();
    key(4'd0);
    start_req();
    chk("start_zero", 16'(bus.busy), 16'd0);
    key(4'd7);
    chk("still_entry", bus.time_bcd, 16'h0007);
    cancel_req();

    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    start_req();
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("tick_cancel", bus.time_bcd, 16'h1000);
    chk("tc_pause", 16'(bus.busy), 16'd1);
    start_req();
    ticks(1);
    chk("wrap_0959", bus.time_bcd, 16'h0959);
    cancel_req(); cancel_req();
    chk("cancel2", bus.time_bcd, 16'h0000);

    key(4'd5);
    start_req();
    ticks(1);
    clear = 1'b0;
    step();
    chk("clr_mag", 16'(bus.mag_on), 16'd0);
    chk("clr_time", bus.time_bcd, 16'h0000);
    clear = 1'b1;
    key(4'd1);
    start_req();
    ticks(1);
    chk("done_1s", 16'(bus.done), 16'd1);
    key(4'd3);
    chk("dkey_done", 16'(bus.done), 16'd0);
    chk("dkey_time", bus.time_bcd, 16'h0000);
    key(4'd4);
    chk("dkey_fresh", bus.time_bcd, 16'h0004);
    cancel_req();

    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 29) == 0) bus.door_closed = ~bus.door_closed;
      clear = ($urandom_range(0, 499) != 0);
      r = int'($urandom_range(0, 15));
      step(r < 4, 4'($urandom_range(0, 15)), r == 4 || r == 5, r == 6,
           $urandom_range(0, 3) == 0);
    end

    clear = 1'b1;
    bus.door_closed = 1'b1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
